// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber polynomial MAC engine:
// register window offsets, status bits, FSM states, mod-Q helper.
package kyber_pkg;

    localparam logic [9:0] A_OFF      = 10'h000;
    localparam logic [9:0] B_OFF      = 10'h100;
    localparam logic [9:0] C_OFF      = 10'h200;
    localparam logic [9:0] RES_OFF    = 10'h300;
    localparam logic [9:0] CTRL_OFF   = 10'h3F0;
    localparam logic [9:0] STATUS_OFF = 10'h3F4;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        MAC,
        FINAL
    } state_t;

    // Remainder by a constant modulus; q folds to a constant at each use.
    function automatic logic [31:0] modq_reduce(
        input logic [31:0] x,
        input logic [31:0] q
    );
        return x % q;
    endfunction

endpackage

// File: rtl/kyber_modq_mac.sv
// Combinational (acc +/- a*b) mod Q with a single
// conditional correction after the add or subtract.
module kyber_modq_mac
    import kyber_pkg::*;
#(
    parameter int Q  = 17,
    parameter int CW = $clog2(Q)
) (
    input  logic [CW-1:0] i_acc,
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_sub,
    output logic [CW-1:0] o_res
);

    localparam logic [CW:0] QW = (CW+1)'(Q);

    logic [2*CW-1:0] w_prod;
    logic [CW-1:0]   w_p;
    logic [CW:0]     w_add;
    logic [CW:0]     w_dif;

    assign w_prod = (2*CW)'(i_a) * (2*CW)'(i_b);
    assign w_p    = CW'(modq_reduce(32'(w_prod), 32'(Q)));
    assign w_add  = {1'b0, i_acc} + {1'b0, w_p};
    assign w_dif  = {1'b0, i_acc} - {1'b0, w_p};

    // Pick the corrected sum or difference; a borrow shows in the top bit.
    always_comb begin
        o_res = '0;
        if (i_sub) begin
            o_res = w_dif[CW] ? CW'(w_dif + QW) : CW'(w_dif);
        end else begin
            o_res = (w_add >= QW) ? CW'(w_add - QW) : CW'(w_add);
        end
    end

endmodule

// File: rtl/kyber_polymac_mmio.sv
// Memory-mapped negacyclic polynomial multiply-accumulate engine:
// res = c +/- sum_i a_i*b_i in Z_Q[x]/(x^N+1), one product per cycle.
module kyber_polymac_mmio
    import kyber_pkg::*;
#(
    parameter int          N         = 4,
    parameter int          Q         = 17,
    parameter int          K         = 2,
    parameter int          CW        = $clog2(Q),
    parameter logic [31:0] BASE_ADDR = 32'h4000_7000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] addr_Req,
    input  logic [31:0] data_Req,
    input  logic        wen_Req,
    input  logic [7:0]  bytelane_Req,
    output logic [31:0] data_Resp
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int AW = (K*N > 1) ? $clog2(K*N) : 1;

    logic [CW-1:0] r_a   [K*N];
    logic [CW-1:0] r_b   [K*N];
    logic [CW-1:0] r_c   [N];
    logic [CW-1:0] r_res [N];
    logic [CW-1:0] r_acc [N];
    logic [CW-1:0] w_fin [N];

    state_t        r_state, w_next;
    logic          r_mode, r_done, r_err;
    logic [IW-1:0] r_i;
    logic [NW-1:0] r_j, r_k;

    logic [31:0]   w_off;
    logic [5:0]    w_idx;
    logic          w_inwin, w_is_a, w_is_b, w_is_c, w_is_res;
    logic          w_is_ctrl, w_is_stat, w_wr, w_busy;
    logic          w_wcoef, w_err_set, w_start, w_last;
    logic [CW-1:0] w_raw, w_wval, w_mac;
    logic [AW-1:0] w_aidx, w_bidx, w_ridx;
    logic [NW:0]   w_t;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_unused  = ^{bytelane_Req[7:1], data_Req};

    assign w_off     = addr_Req - BASE_ADDR;
    assign w_idx     = w_off[7:2];
    assign w_inwin   = (w_off[31:10] == '0) && (w_off[1:0] == 2'b00);
    assign w_is_ctrl = w_inwin && (w_off[9:0] == CTRL_OFF);
    assign w_is_stat = w_inwin && (w_off[9:0] == STATUS_OFF);
    assign w_is_a    = w_inwin && (w_off[9:8] == A_OFF[9:8])
                     && (32'(w_idx) < K*N);
    assign w_is_b    = w_inwin && (w_off[9:8] == B_OFF[9:8])
                     && (32'(w_idx) < K*N);
    assign w_is_c    = w_inwin && (w_off[9:8] == C_OFF[9:8])
                     && (32'(w_idx) < N);
    assign w_is_res  = w_inwin && (w_off[9:8] == RES_OFF[9:8])
                     && (32'(w_idx) < N) && !w_is_ctrl && !w_is_stat;

    assign w_busy    = (r_state != IDLE);
    assign w_wr      = enable && wen_Req && bytelane_Req[0];
    assign w_wcoef   = w_wr && (w_is_a || w_is_b || w_is_c) && !w_busy;
    assign w_err_set = w_wr && (w_is_a || w_is_b || w_is_c || w_is_ctrl)
                     && w_busy;
    assign w_start   = w_wr && w_is_ctrl && !w_busy && data_Req[0];

    assign w_raw     = data_Req[CW-1:0];
    assign w_wval    = (32'(w_raw) >= Q) ? CW'(32'(w_raw) - Q) : w_raw;
    assign w_ridx    = AW'(w_idx);

    assign w_aidx    = AW'(r_i) * AW'(N) + AW'(r_j);
    assign w_bidx    = AW'(r_i) * AW'(N) + AW'(r_k);
    assign w_t       = {1'b0, r_j} + {1'b0, r_k};
    assign w_last    = (r_i == IW'(K-1)) && (r_j == NW'(N-1))
                     && (r_k == NW'(N-1));

    kyber_modq_mac #(.Q(Q), .CW(CW)) u_mac (
        .i_acc (r_acc[w_t[NW-1:0]]),
        .i_a   (r_a[w_aidx]),
        .i_b   (r_b[w_bidx]),
        .i_sub (w_t[NW]),
        .o_res (w_mac)
    );

    for (genvar g = 0; g < N; g++) begin : g_fin
        kyber_modq_mac #(.Q(Q), .CW(CW)) u_fin (
            .i_acc (r_c[g]),
            .i_a   (r_acc[g]),
            .i_b   (CW'(1)),
            .i_sub (r_mode),
            .o_res (w_fin[g])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: start -> INIT -> MAC (K*N*N) -> FINAL -> IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = INIT;
            INIT:    w_next = MAC;
            MAC:     if (w_last) w_next = FINAL;
            FINAL:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Register file, accumulator, counters and sticky status bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < K*N; n++) begin
                r_a[n] <= '0;
                r_b[n] <= '0;
            end
            for (int n = 0; n < N; n++) begin
                r_c[n]   <= '0;
                r_res[n] <= '0;
                r_acc[n] <= '0;
            end
            r_mode <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
        end else begin
            if (w_wcoef && w_is_a) r_a[w_ridx] <= w_wval;
            if (w_wcoef && w_is_b) r_b[w_ridx] <= w_wval;
            if (w_wcoef && w_is_c) r_c[NW'(w_idx)] <= w_wval;
            if (w_start) begin
                r_mode <= data_Req[1];
                r_done <= 1'b0;
            end
            if (w_wr && w_is_stat) begin
                if (data_Req[ST_DONE]) r_done <= 1'b0;
                if (data_Req[ST_ERR])  r_err  <= 1'b0;
            end
            if (w_err_set) r_err <= 1'b1;
            unique case (r_state)
                INIT: begin
                    for (int n = 0; n < N; n++) r_acc[n] <= '0;
                    r_i <= '0;
                    r_j <= '0;
                    r_k <= '0;
                end
                MAC: begin
                    r_acc[w_t[NW-1:0]] <= w_mac;
                    r_k <= r_k + 1'b1;
                    if (r_k == NW'(N-1)) begin
                        r_j <= r_j + 1'b1;
                        if (r_j == NW'(N-1)) r_i <= r_i + 1'b1;
                    end
                end
                FINAL: begin
                    for (int n = 0; n < N; n++) r_res[n] <= w_fin[n];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read mux; CTRL and unmapped addresses read as zero.
    always_comb begin
        w_rdata = '0;
        if (w_is_a)         w_rdata = 32'(r_a[w_ridx]);
        else if (w_is_b)    w_rdata = 32'(r_b[w_ridx]);
        else if (w_is_c)    w_rdata = 32'(r_c[NW'(w_idx)]);
        else if (w_is_res)  w_rdata = 32'(r_res[NW'(w_idx)]);
        else if (w_is_stat) w_rdata = {29'd0, r_err, r_done, w_busy};
    end

    // Registered read response; write cycles return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       data_Resp <= '0;
        else if (wen_Req) data_Resp <= '0;
        else              data_Resp <= w_rdata;
    end

endmodule

// File: tb/tb_kyber_polymac_mmio.sv
// Directed bench for kyber_polymac_mmio at default parameters
// (N=4, Q=17, K=2); expected values are hand-computed.
module tb_kyber_polymac_mmio;

    localparam logic [31:0] BASE = 32'h4000_7000;
    localparam logic [31:0] A0   = BASE;
    localparam logic [31:0] BOFF = BASE + 32'h100;
    localparam logic [31:0] COFF = BASE + 32'h200;
    localparam logic [31:0] ROFF = BASE + 32'h300;
    localparam logic [31:0] CTRL = BASE + 32'h3F0;
    localparam logic [31:0] STAT = BASE + 32'h3F4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] addr_Req = '0;
    logic [31:0] data_Req = '0;
    logic        wen_Req = 1'b0;
    logic [7:0]  bytelane_Req = '0;
    logic [31:0] data_Resp;

    int errors = 0;
    int checks = 0;
    int va[8];
    int vb[8];
    int vc[4];

    always #5 clk = ~clk;

    kyber_polymac_mmio dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .addr_Req     (addr_Req),
        .data_Req     (data_Req),
        .wen_Req      (wen_Req),
        .bytelane_Req (bytelane_Req),
        .data_Resp    (data_Resp)
    );

    task automatic wr_raw(input logic [31:0] a, input logic [31:0] d,
                          input logic en, input logic [7:0] bl);
        @(negedge clk);
        addr_Req = a;
        data_Req = d;
        enable = en;
        bytelane_Req = bl;
        wen_Req = 1'b1;
        @(posedge clk);
        #1;
        wen_Req = 1'b0;
        enable = 1'b0;
        bytelane_Req = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_raw(a, d, 1'b1, 8'h01);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_Req = a;
        wen_Req = 1'b0;
        @(posedge clk);
        #1;
        d = data_Resp;
    endtask

    task automatic load();
        for (int n = 0; n < 8; n++) begin
            wr(A0 + 32'(4*n), 32'(va[n]));
            wr(BOFF + 32'(4*n), 32'(vb[n]));
        end
        for (int n = 0; n < 4; n++) wr(COFF + 32'(4*n), 32'(vc[n]));
    endtask

    // Reads STATUS every cycle until busy drops; counts busy reads.
    task automatic poll(output int nb, output logic [31:0] st);
        bit fin;
        fin = 0;
        nb = 0;
        st = '0;
        for (int n = 0; n < 200 && !fin; n++) begin
            rd(STAT, st);
            if (st[0]) nb++;
            else fin = 1;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL poll_timeout: busy still %0d after 200 reads",
                     st[0]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(STAT, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_status: got %0d expected 0", d);
        end
        rd(ROFF, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_res0: got %0d expected 0", d);
        end
        rd(A0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_a0: got %0d expected 0", d);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        int vals[4] = '{20, 17, 16, 0};
        int exps[4] = '{3, 0, 16, 0};
        for (int n = 0; n < 4; n++) begin
            wr(A0, 32'(vals[n]));
            rd(A0, d);
            checks++;
            if (d !== 32'(exps[n])) begin
                errors++;
                $display("FAIL coef_reduce[%0d]: got %0d expected %0d",
                         vals[n], d, exps[n]);
            end
        end
        wr(A0, 32'd20);
        wr_raw(A0, 32'd5, 1'b0, 8'h01);
        rd(A0, d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL enable_gate: got %0d expected 3", d);
        end
        wr_raw(A0, 32'd5, 1'b1, 8'hFE);
        rd(A0, d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL lane_gate: got %0d expected 3", d);
        end
        wr(COFF, 32'd7);
        checks++;
        if (data_Resp !== 32'd0) begin
            errors++;
            $display("FAIL write_cycle_resp: got %0d expected 0", data_Resp);
        end
        rd(COFF, d);
        checks++;
        if (d !== 32'd7) begin
            errors++;
            $display("FAIL c0_readback: got %0d expected 7", d);
        end
        rd(32'h4000_8000, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_read: got %0d expected 0", d);
        end
        rd(CTRL, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL ctrl_read: got %0d expected 0", d);
        end
    endtask

    task automatic test_mac_add();
        logic [31:0] d, st;
        int nb;
        int exp[4] = '{3, 4, 5, 6};
        va = '{1, 0, 0, 0, 0, 0, 0, 0};
        vb = '{3, 4, 5, 6, 0, 0, 0, 0};
        vc = '{0, 0, 0, 0};
        load();
        wr(CTRL, 32'd1);
        poll(nb, st);
        checks++;
        if (nb !== 34) begin
            errors++;
            $display("FAIL add_busy_cycles: got %0d expected 34", nb);
        end
        checks++;
        if (st !== 32'd2) begin
            errors++;
            $display("FAIL add_status: got %0d expected 2", st);
        end
        for (int j = 0; j < 4; j++) begin
            rd(ROFF + 32'(4*j), d);
            checks++;
            if (d !== 32'(exp[j])) begin
                errors++;
                $display("FAIL add_res[%0d]: got %0d expected %0d",
                         j, d, exp[j]);
            end
        end
        wr(CTRL, 32'd2);
        rd(STAT, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL start0_noop: got %0d expected 2", d);
        end
        wr(STAT, 32'd2);
        rd(STAT, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL done_clear: got %0d expected 0", d);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d, st;
        int nb;
        int exp[4] = '{13, 1, 2, 3};
        va = '{0, 1, 0, 0, 0, 0, 0, 0};
        vb = '{1, 2, 3, 4, 0, 0, 0, 0};
        vc = '{0, 0, 0, 0};
        load();
        wr(CTRL, 32'd1);
        poll(nb, st);
        for (int j = 0; j < 4; j++) begin
            rd(ROFF + 32'(4*j), d);
            checks++;
            if (d !== 32'(exp[j])) begin
                errors++;
                $display("FAIL wrap_res[%0d]: got %0d expected %0d",
                         j, d, exp[j]);
            end
        end
    endtask

    task automatic test_k_accum();
        logic [31:0] d, st;
        int nb;
        va = '{1, 0, 0, 0, 2, 0, 0, 0};
        vb = '{1, 1, 1, 1, 8, 8, 8, 8};
        vc = '{0, 0, 0, 0};
        load();
        wr(CTRL, 32'd1);
        poll(nb, st);
        for (int j = 0; j < 4; j++) begin
            rd(ROFF + 32'(4*j), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL kacc_res[%0d]: got %0d expected 0", j, d);
            end
        end
    endtask

    task automatic test_sub_busy();
        logic [31:0] d, st;
        int nb1, nb2;
        int exp[4] = '{4, 3, 2, 1};
        va = '{1, 0, 0, 0, 0, 0, 0, 0};
        vb = '{1, 2, 3, 4, 0, 0, 0, 0};
        vc = '{5, 5, 5, 5};
        load();
        wr(CTRL, 32'd3);
        nb1 = 0;
        for (int n = 0; n < 5; n++) begin
            rd(STAT, st);
            if (st[0]) nb1++;
        end
        wr(CTRL, 32'd1);
        wr(A0, 32'd9);
        poll(nb2, st);
        checks++;
        if (nb1 + 2 + nb2 !== 34) begin
            errors++;
            $display("FAIL sub_busy_cycles: got %0d expected 34",
                     nb1 + 2 + nb2);
        end
        checks++;
        if (st !== 32'd6) begin
            errors++;
            $display("FAIL sub_status_err: got %0d expected 6", st);
        end
        for (int j = 0; j < 4; j++) begin
            rd(ROFF + 32'(4*j), d);
            checks++;
            if (d !== 32'(exp[j])) begin
                errors++;
                $display("FAIL sub_res[%0d]: got %0d expected %0d",
                         j, d, exp[j]);
            end
        end
        rd(A0, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL busy_write_drop: got %0d expected 1", d);
        end
        wr(STAT, 32'd4);
        rd(STAT, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL err_clear: got %0d expected 2", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, st;
        int nb;
        int exp[4] = '{3, 4, 5, 6};
        wr(CTRL, 32'd1);
        @(negedge clk);
        addr_Req = ROFF;
        wen_Req = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (data_Resp !== 32'd4) begin
            errors++;
            $display("FAIL res_hold_midrun: got %0d expected 4", data_Resp);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (data_Resp !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_resp: got %0d expected 0", data_Resp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd(STAT, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL midreset_status: got %0d expected 0", d);
        end
        for (int j = 0; j < 4; j++) begin
            rd(ROFF + 32'(4*j), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL midreset_res[%0d]: got %0d expected 0", j, d);
            end
        end
        va = '{1, 0, 0, 0, 0, 0, 0, 0};
        vb = '{3, 4, 5, 6, 0, 0, 0, 0};
        vc = '{0, 0, 0, 0};
        load();
        wr(CTRL, 32'd1);
        poll(nb, st);
        checks++;
        if (nb !== 34) begin
            errors++;
            $display("FAIL rerun_busy_cycles: got %0d expected 34", nb);
        end
        for (int j = 0; j < 4; j++) begin
            rd(ROFF + 32'(4*j), d);
            checks++;
            if (d !== 32'(exp[j])) begin
                errors++;
                $display("FAIL rerun_res[%0d]: got %0d expected %0d",
                         j, d, exp[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_mac_add();
        test_wrap();
        test_k_accum();
        test_sub_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
